// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI link (responder and reader side).
//   SPI_WORD_W  : bits per SPI frame on this link.
//   spi_state_e : responder FSM states.
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_WORD_W = 16;

    typedef enum logic [1:0] {
        ARMWAIT = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// N-stage synchronizer for an asynchronous level input, followed by a
// registered edge detector. A pin edge shows up on the strobes STAGES+1 clk
// later; level_o shows it after STAGES clk.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   d_i       : asynchronous input
//   level_o   : synchronized level
//   rise_o    : one-cycle strobe on a synchronized rising edge
//   fall_o    : one-cycle strobe on a synchronized falling edge
// ---------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Everything resets low: a CS that is already low at reset then produces
    // no strobe, so a frame in flight is never joined mid-stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_sdo_responder.sv
// ---------------------------------------------------------------------------
// spi_sdo_responder
// SPI slave-side transmitter (CPOL=0). Takes parallel words through a
// one-deep holding buffer and shifts them out MSB-first on SDO while the
// master holds CS low. SCLK/CS are oversampled on clk.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   SCLK, CS     : serial clock and active-low chip select from the master
//   SDO, sdo_oe  : serial data out and its tristate enable
//   tx_data/tx_valid/tx_ready : word input handshake (ready = buffer empty)
//   busy         : frame in progress (SHIFT or DONE)
//   frame_done   : one-cycle pulse at the end of an armed frame
//   short_frame  : qualifies frame_done, fewer than DATA_W SCLK falls seen
//   underrun     : one-cycle pulse when a frame starts with nothing to send
// All outputs are registered.
// ---------------------------------------------------------------------------
module spi_sdo_responder
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_WORD_W,
    parameter logic [DATA_W-1:0] IDLE_WORD   = '0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              CS,
    output logic              SDO,
    output logic              sdo_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              short_frame,
    output logic              underrun
);

    localparam int             CW      = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DATA_W);

    // ---------------- input conditioning ----------------
    logic cs_level, cs_rise, cs_fall;
    logic sclk_fall;
    logic sclk_level_unused, sclk_rise_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .d_i     (CS),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .d_i     (SCLK),
        .level_o (sclk_level_unused),
        .rise_o  (sclk_rise_unused),
        .fall_o  (sclk_fall)
    );

    // ---------------- state ----------------
    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic sdo_q, sdo_d;
    logic sdo_oe_q, sdo_oe_d;
    logic tx_ready_q;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;
    logic short_q, short_d;
    logic underrun_q, underrun_d;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        short_d      = 1'b0;
        underrun_d   = 1'b0;

        // Normal buffer fill; tx_ready_q mirrors ~buf_full_q.
        if (tx_valid && tx_ready_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        case (state_q)
            ARMWAIT: begin
                if (cs_level) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (cs_fall) begin
                    if (buf_full_q) begin
                        shift_d    = buf_q;
                        buf_full_d = 1'b0;
                    end else if (tx_valid) begin
                        // Bypass: the word goes straight to the shifter and
                        // must not also land in the buffer.
                        shift_d    = tx_data;
                        buf_d      = buf_q;
                        buf_full_d = 1'b0;
                    end else begin
                        shift_d    = IDLE_WORD;
                        underrun_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // cs_rise has priority over a coincident sclk_fall.
                if (cs_rise) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                    short_d      = (cnt_q < CNT_MAX);
                end else if (sclk_fall) begin
                    // Zero fill makes SDO read 0 once all bits are out.
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    if (cnt_q < CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = ARMWAIT;
            end
        endcase

        sdo_oe_d = (state_d == SHIFT) && !cs_level;
        sdo_d    = shift_d[DATA_W-1] && sdo_oe_d;
        busy_d   = (state_d == SHIFT) || (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARMWAIT;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            sdo_q        <= 1'b0;
            sdo_oe_q     <= 1'b0;
            tx_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            short_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            sdo_q        <= sdo_d;
            sdo_oe_q     <= sdo_oe_d;
            tx_ready_q   <= ~buf_full_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            short_q      <= short_d;
            underrun_q   <= underrun_d;
        end
    end

    assign SDO         = sdo_q;
    assign sdo_oe      = sdo_oe_q;
    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_sdo_responder.sv
module tb_spi_sdo_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SCLK = 1'b0;
    logic        CS = 1'b1;
    logic        SDO;
    logic        sdo_oe;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic        short_frame;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse monitors (only written here, only read by the stimulus block).
    int   fd_cnt = 0;
    int   ur_cnt = 0;
    logic last_short = 1'b0;

    always #5 clk = ~clk;

    spi_sdo_responder #(
        .DATA_W      (16),
        .IDLE_WORD   (16'hDEAD),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .SCLK        (SCLK),
        .CS          (CS),
        .SDO         (SDO),
        .sdo_oe      (sdo_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .underrun    (underrun)
    );

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt     <= fd_cnt + 1;
            last_short <= short_frame;
        end
        if (underrun) begin
            ur_cnt <= ur_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    // Advance n clocks, ending 1 time unit after the last rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Master model: frames nfalls SCLK cycles, samples SDO at each rise.
    // With bypass set, tx_valid is raised exactly in the cycle the
    // synchronized CS fall reaches the FSM (3 clk after the pin edge).
    task automatic run_frame(input int nfalls, input bit bypass, input logic [15:0] bw,
                             output logic [31:0] rx, output logic oe_first);
        rx       = '0;
        oe_first = 1'b0;
        CS       = 1'b0;
        if (bypass) begin
            tick(3);
            tx_data  = bw;
            tx_valid = 1'b1;
            tick(1);
            tx_valid = 1'b0;
            tick(4);
        end else begin
            tick(8);
        end
        for (int i = 0; i < nfalls; i++) begin
            SCLK = 1'b1;
            rx   = {rx[30:0], SDO};
            if (i == 0) oe_first = sdo_oe;
            tick(5);
            SCLK = 1'b0;
            tick(5);
        end
        CS = 1'b1;
        tick(8);
    endtask

    logic [31:0] rx;
    logic        oe;
    int          fd0, ur0;
    logic        bad;

    initial begin
        // ---- reset state ----
        tick(3);
        check_val("rst_sdo",      {31'd0, SDO},         32'd0);
        check_val("rst_sdo_oe",   {31'd0, sdo_oe},      32'd0);
        check_val("rst_tx_ready", {31'd0, tx_ready},    32'd1);
        check_val("rst_busy",     {31'd0, busy},        32'd0);
        check_val("rst_pulses",   {29'd0, frame_done, short_frame, underrun}, 32'd0);
        rst = 1'b0;
        tick(6);

        // ---- 1: normal 16-bit frame ----
        load_word(16'hA5C3);
        check_val("t1_ready_low", {31'd0, tx_ready}, 32'd0);
        fd0 = fd_cnt; ur0 = ur_cnt;
        run_frame(16, 1'b0, 16'h0, rx, oe);
        check_val("t1_rx",        rx,                       32'h0000A5C3);
        check_val("t1_oe",        {31'd0, oe},              32'd1);
        check_val("t1_done",      fd_cnt - fd0,             32'd1);
        check_val("t1_short",     {31'd0, last_short},      32'd0);
        check_val("t1_ready",     {31'd0, tx_ready},        32'd1);
        check_val("t1_busy",      {31'd0, busy},            32'd0);

        // ---- 2: underrun sends IDLE_WORD, then a loaded word ----
        fd0 = fd_cnt; ur0 = ur_cnt;
        run_frame(16, 1'b0, 16'h0, rx, oe);
        check_val("t2_rx_idle",   rx,                       32'h0000DEAD);
        check_val("t2_underrun",  ur_cnt - ur0,             32'd1);
        load_word(16'h1234);
        ur0 = ur_cnt;
        run_frame(16, 1'b0, 16'h0, rx, oe);
        check_val("t2_rx_word",   rx,                       32'h00001234);
        check_val("t2_no_under",  ur_cnt - ur0,             32'd0);

        // ---- 3: bypass on cs_fall with empty buffer ----
        ur0 = ur_cnt;
        run_frame(16, 1'b1, 16'h00FF, rx, oe);
        check_val("t3_rx",        rx,                       32'h000000FF);
        check_val("t3_no_under",  ur_cnt - ur0,             32'd0);
        check_val("t3_ready",     {31'd0, tx_ready},        32'd1);

        // ---- 4: short frame, then the next word ----
        load_word(16'hFFFF);
        fd0 = fd_cnt;
        run_frame(9, 1'b0, 16'h0, rx, oe);
        check_val("t4_rx9",       rx,                       32'h000001FF);
        check_val("t4_done",      fd_cnt - fd0,             32'd1);
        check_val("t4_short",     {31'd0, last_short},      32'd1);
        load_word(16'h2468);
        run_frame(16, 1'b0, 16'h0, rx, oe);
        check_val("t4_next",      rx,                       32'h00002468);

        // ---- 5: 20 SCLK clocks, extra bits read 0 ----
        load_word(16'h8001);
        fd0 = fd_cnt;
        run_frame(20, 1'b0, 16'h0, rx, oe);
        check_val("t5_rx20",      rx,                       32'h00080010);
        check_val("t5_short",     {31'd0, last_short},      32'd0);

        // ---- 6: reset at bit 6 with CS held low ----
        load_word(16'h5555);
        CS = 1'b0;
        tick(8);
        for (int i = 0; i < 6; i++) begin
            SCLK = 1'b1; tick(5);
            SCLK = 1'b0; tick(5);
        end
        check_val("t6_busy_pre",  {31'd0, busy},            32'd1);
        rst = 1'b1;
        #1;
        check_val("t6_rst_now",   {28'd0, SDO, sdo_oe, busy, tx_ready}, 32'h1);
        tick(1);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            SCLK = 1'b1;
            if (SDO !== 1'b0 || busy !== 1'b0 || sdo_oe !== 1'b0) bad = 1'b1;
            tick(5);
            SCLK = 1'b0;
            if (SDO !== 1'b0 || busy !== 1'b0 || sdo_oe !== 1'b0) bad = 1'b1;
            tick(5);
        end
        check_val("t6_quiet",     {31'd0, bad},             32'd0);
        CS = 1'b1;
        tick(8);
        load_word(16'h3C5A);
        run_frame(16, 1'b0, 16'h0, rx, oe);
        check_val("t6_after",     rx,                       32'h00003C5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_sdo_responder.md
# spi_sdo_responder

SPI responder (slave-side transmitter) that drives SDO for our SPI reader. Its existing counterpart is the master that issues CS/SCLK and samples SDO to fill a 16-bit word. This block sits on the far end of that link: it accepts parallel words from local logic and shifts them out MSB-first whenever the master frames a transfer. It serves as a sensor emulator for board bring-up and as the responder in loopback tests. SCLK and CS are treated as asynchronous inputs and oversampled on `clk`.

## Interface
- `DATA_W`, 16: bits per frame.
- `IDLE_WORD`, 16'h0000: word sent when a frame starts with no data buffered.
- `SYNC_STAGES`, 2: synchronizer depth for SCLK and CS (≥2).
- `clk` in 1: system clock. One clock only.
- `rst` in 1: reset, asynchronous, active-high.
- `SCLK` in 1: serial clock from master; CPOL=0, idles low.
- `CS` in 1: chip select from master, active-low.
- `SDO` out 1: serial data to master.
- `sdo_oe` out 1: high while CS is low and the block is armed; board-level tristate enable.
- `tx_data` in DATA_W: word to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the one-deep holding buffer is empty.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse after CS rises on an armed frame.
- `short_frame` out 1: qualifies `frame_done`; fewer than DATA_W SCLK falls were seen.
- `underrun` out 1: one-cycle pulse when a frame starts with an empty buffer.

## Operation
- The SCLK and CS inputs pass through synchronizers, then edge detectors. The detectors produce `cs_fall`, `cs_rise` and `sclk_fall`, each a single-cycle strobe.
- Holding buffer:
  - A word is accepted on `tx_valid && tx_ready`.
  - `tx_ready` drops the cycle after acceptance.
  - `tx_ready` rises again the cycle after the buffer is consumed.
- FSM states are ARMWAIT, IDLE, SHIFT and DONE.
- ARMWAIT (reset state): the block waits for synchronized CS to be high, then goes to IDLE. This prevents joining a frame mid-stream after reset.
- IDLE, on `cs_fall`:
  - The shift register loads the buffer word and the buffer empties.
  - If the buffer is empty but `tx_valid` is high in the same cycle, the word bypasses the buffer into the shift register and counts as accepted.
  - If the buffer is empty and `tx_valid` is low, the shift register loads IDLE_WORD and `underrun` pulses.
  - The bit counter clears, the state goes to SHIFT, and SDO presents bit DATA_W-1.
- SHIFT:
  - On each `sclk_fall`, the register shifts left with zero fill and the counter increments. The master samples on SCLK rising.
  - After DATA_W falls, SDO holds 0 for any extra SCLK falls; the counter saturates at DATA_W.
  - On `cs_rise`, the state goes to DONE.
- DONE: lasts one cycle. `frame_done`=1 and `short_frame`=(count<DATA_W). Then the state goes to IDLE.
- A short frame's word is discarded, not retransmitted.
- `cs_rise` and `sclk_fall` in the same cycle: `cs_rise` wins and no shift occurs.
- `busy` is 1 in SHIFT and DONE.
- `sdo_oe` = ~CS_sync in SHIFT, 0 otherwise.
- When `sdo_oe` is 0, SDO is driven 0.

## Timing
- Reset values: SDO=0, sdo_oe=0, tx_ready=1, busy=0, frame_done=0, short_frame=0, underrun=0. The buffer and shift register are 0, and the FSM is in ARMWAIT.
- Input-to-strobe latency is SYNC_STAGES+1 clk.
- SDO updates one clk after `sclk_fall`. Total latency from the SCLK falling pin edge to SDO is SYNC_STAGES+2 clk.
- Constraint: the SCLK high and low phases are each ≥ SYNC_STAGES+3 clk. CS low must precede the first SCLK rise by the same amount.
- All outputs are registered.
- Asserting `rst` mid-frame forces the reset values immediately. The block returns to ARMWAIT and ignores the remainder of the frame until CS is seen high.

## Structure
- Package `spi_pkg` holds:
  - the FSM state enum (ARMWAIT, IDLE, SHIFT, DONE);
  - a shared `SPI_WORD_W` = 16 constant, also used by the reader side.
- Sub-module `spi_sync_edge` provides an N-stage synchronizer with rise/fall strobes. It is instantiated twice, once for SCLK and once for CS.
- The top level contains the buffer, shift register, counter and FSM.

## Test plan
- Load 16'hA5C3, then run a 16-bit frame with SCLK = clk/10. Expect: the master-side model samples 16'hA5C3, `frame_done`=1, `short_frame`=0, and `tx_ready` returns to 1 after the frame starts.
- Start a frame with an empty buffer and IDLE_WORD=16'hDEAD. Expect: `underrun` pulses once, 16'hDEAD is received, and a later frame with a loaded 16'h1234 delivers 16'h1234.
- Drive `tx_valid` with 16'h00FF in the same cycle as `cs_fall` on an empty buffer. Expect: 16'h00FF is sent, no `underrun`, and `tx_ready` stays high afterward.
- Raise CS after 9 SCLK falls with 16'hFFFF loaded. Expect: `frame_done` with `short_frame`=1, and the next frame sends the next loaded word, not the remainder of 16'hFFFF.
- Send 20 SCLK clocks with 16'h8001 loaded. Expect: the first 16 sampled bits are 16'h8001 and the last 4 are 0.
- Assert `rst` at bit 6 of a frame while CS stays low. Expect: outputs go to reset values immediately, SDO stays 0 and `busy`=0 until CS rises, and the next frame transfers correctly.
